// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// fetch FSM state encoding, reset PC default and small decode helpers.
package inst_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_FETCH   = 2'd1,
    S_DECODE  = 2'd2,
    S_RESOLVE = 2'd3
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] inst);
    return inst[31:26];
  endfunction

endpackage

// File: rtl/inst_fetch_unit_next_pc_gen.sv
// Combinational next-PC generator: sequential, branch and jump targets
// with jump taking priority over a taken branch.
module next_pc_gen
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [25:0]       inst_i,
  input  logic              branch_eq_i,
  input  logic              branch_neq_i,
  input  logic              jump_i,
  input  logic              alu_zero_i,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] branch_tgt_s;
  logic [ADDR_W-1:0] jump_tgt_s;
  logic              take_branch_s;

  assign pc_plus4_o = pc_i + ADDR_W'(4);

  // Word-scaled immediate: sign-extend the 16-bit offset and append two zero bits.
  assign branch_tgt_s  = pc_plus4_o + {{(ADDR_W-18){inst_i[15]}}, inst_i[15:0], 2'b00};
  assign jump_tgt_s    = {pc_plus4_o[ADDR_W-1:28], inst_i[25:0], 2'b00};
  assign take_branch_s = (branch_eq_i & alu_zero_i) | (branch_neq_i & ~alu_zero_i);

  // Priority select of the next fetch address.
  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jump_i) begin
      next_pc_o = jump_tgt_s;
    end else if (take_branch_s) begin
      next_pc_o = branch_tgt_s;
    end else begin
      next_pc_o = pc_plus4_o;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Multicycle instruction fetch/sequencing stage: fetches one word over a
// req/ack port, holds it for the control unit, then resolves the next PC.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter int              INST_W   = 32,
  parameter logic [63:0]     RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              branch_eq,
  input  logic              branch_neq,
  input  logic              jump,
  input  logic              alu_zero,
  output logic [INST_W-1:0] inst_out,
  output logic [5:0]        opcode,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] next_pc_s;
  logic [ADDR_W-1:0] pc_plus4_s;

  next_pc_gen #(.ADDR_W(ADDR_W)) u_next_pc_gen (
    .pc_i         (pc_q),
    .inst_i       (inst_q[25:0]),
    .branch_eq_i  (branch_eq),
    .branch_neq_i (branch_neq),
    .jump_i       (jump),
    .alu_zero_i   (alu_zero),
    .pc_plus4_o   (pc_plus4_s),
    .next_pc_o    (next_pc_s)
  );

  // Next-state and register update logic for the fetch sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (stall) begin
          state_d = S_RESOLVE;
        end else begin
          pc_d    = next_pc_s;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
    // Request is registered so it rises with entry to FETCH and drops right after ack.
    req_d = (state_d == S_FETCH);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC[ADDR_W-1:0];
      inst_q  <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_out   = inst_q;
  assign opcode     = opcode_of(inst_q);
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_s;

endmodule
